// File: rtl/spi_slave.sv
// Mode-0 SPI target: decodes cmd/addr/data frames into single-cycle register-bank strobes.
// Everything runs on sclk; spi_clk, cs_n and mosi are oversampled, so sclk must be >= 16x spi_clk.
module spi_slave #(
  parameter int                   CMD_WIDTH  = 8,
  parameter int                   ADDR_WIDTH = 8,
  parameter int                   DATA_WIDTH = 8,
  parameter logic [CMD_WIDTH-1:0] CMD_WRITE  = CMD_WIDTH'(8'h01),
  parameter logic [CMD_WIDTH-1:0] CMD_READ   = CMD_WIDTH'(8'h02)
) (
  input  logic                  sclk,
  input  logic                  rst_n,
  input  logic                  spi_clk,
  input  logic                  cs_n,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  miso_oe,
  output logic [ADDR_WIDTH-1:0] reg_addr,
  output logic [DATA_WIDTH-1:0] reg_wdata,
  output logic                  reg_wr_en,
  output logic                  reg_rd_en,
  input  logic [DATA_WIDTH-1:0] reg_rdata,
  output logic                  busy,
  output logic                  frame_err
);

  localparam int MAXW_CA = (CMD_WIDTH > ADDR_WIDTH) ? CMD_WIDTH : ADDR_WIDTH;
  localparam int MAXW    = (MAXW_CA > DATA_WIDTH) ? MAXW_CA : DATA_WIDTH;
  localparam int CNT_W   = (MAXW > 1) ? $clog2(MAXW) : 1;

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_CMD   = 4'd1;
  localparam logic [3:0] S_ADDR  = 4'd2;
  localparam logic [3:0] S_WRITE = 4'd3;
  localparam logic [3:0] S_WLOAD = 4'd4;
  localparam logic [3:0] S_WSTB  = 4'd5;
  localparam logic [3:0] S_RDREQ = 4'd6;
  localparam logic [3:0] S_RDCAP = 4'd7;
  localparam logic [3:0] S_READ  = 4'd8;
  localparam logic [3:0] S_DONE  = 4'd9;

  // Reset asserts asynchronously but releases on a clean sclk edge.
  logic [1:0] rst_sync_q;
  logic       rst_int_n;

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_int_n = rst_sync_q[1];

  logic [2:0] sck_sync_q;
  logic [2:0] cs_sync_q;
  logic [1:0] mosi_sync_q;

  always_ff @(posedge sclk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      sck_sync_q  <= 3'b000;
      cs_sync_q   <= 3'b111;
      mosi_sync_q <= 2'b00;
    end else begin
      sck_sync_q  <= {sck_sync_q[1:0], spi_clk};
      cs_sync_q   <= {cs_sync_q[1:0], cs_n};
      mosi_sync_q <= {mosi_sync_q[0], mosi};
    end
  end

  logic sck_rise;
  logic sck_fall;
  logic cs_rise;
  logic cs_fall;
  logic cs_s;
  logic mosi_s;

  assign sck_rise = sck_sync_q[1] & ~sck_sync_q[2];
  assign sck_fall = ~sck_sync_q[1] & sck_sync_q[2];
  assign cs_rise  = cs_sync_q[1] & ~cs_sync_q[2];
  assign cs_fall  = ~cs_sync_q[1] & cs_sync_q[2];
  assign cs_s     = cs_sync_q[1];
  assign mosi_s   = mosi_sync_q[1];

  logic [3:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [MAXW-1:0]       sr_q, sr_d;
  logic [CMD_WIDTH-1:0]  cmd_q, cmd_d;
  logic [DATA_WIDTH-1:0] tx_q, tx_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  wr_en_q, wr_en_d;
  logic                  rd_en_q, rd_en_d;
  logic                  ferr_q, ferr_d;

  logic [MAXW-1:0]       sr_shift;
  logic                  cmd_last;
  logic                  addr_last;
  logic                  data_last;

  assign sr_shift  = {sr_q[MAXW-2:0], mosi_s};
  assign cmd_last  = (cnt_q == CNT_W'(CMD_WIDTH - 1));
  assign addr_last = (cnt_q == CNT_W'(ADDR_WIDTH - 1));
  assign data_last = (cnt_q == CNT_W'(DATA_WIDTH - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    cmd_d   = cmd_q;
    tx_d    = tx_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wr_en_d = 1'b0;
    rd_en_d = 1'b0;
    ferr_d  = 1'b0;

    // cs_n release takes priority over any spi_clk edge seen in the same cycle.
    if (cs_rise && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      sr_d    = '0;
      tx_d    = '0;
      case (state_q)
        S_WLOAD: begin
          wdata_d = sr_q[DATA_WIDTH-1:0];
          wr_en_d = 1'b1;
        end
        S_WSTB:  wr_en_d = 1'b1;
        S_DONE:  ferr_d  = 1'b0;
        default: ferr_d  = 1'b1;
      endcase
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cs_fall) begin
            state_d = S_CMD;
            cnt_d   = '0;
            sr_d    = '0;
          end
        end
        S_CMD: begin
          if (sck_rise) begin
            sr_d  = sr_shift;
            cnt_d = cnt_q + 1'b1;
            if (cmd_last) begin
              cnt_d = '0;
              sr_d  = '0;
              cmd_d = sr_shift[CMD_WIDTH-1:0];
              if ((sr_shift[CMD_WIDTH-1:0] == CMD_WRITE) ||
                  (sr_shift[CMD_WIDTH-1:0] == CMD_READ)) begin
                state_d = S_ADDR;
              end else begin
                ferr_d  = 1'b1;
                state_d = S_DONE;
              end
            end
          end
        end
        S_ADDR: begin
          if (sck_rise) begin
            sr_d  = sr_shift;
            cnt_d = cnt_q + 1'b1;
            if (addr_last) begin
              cnt_d  = '0;
              sr_d   = '0;
              addr_d = sr_shift[ADDR_WIDTH-1:0];
              if (cmd_q == CMD_READ) begin
                rd_en_d = 1'b1;
                state_d = S_RDREQ;
              end else begin
                state_d = S_WRITE;
              end
            end
          end
        end
        S_WRITE: begin
          if (sck_rise) begin
            sr_d  = sr_shift;
            cnt_d = cnt_q + 1'b1;
            if (data_last) begin
              cnt_d   = '0;
              state_d = S_WLOAD;
            end
          end
        end
        S_WLOAD: begin
          wdata_d = sr_q[DATA_WIDTH-1:0];
          state_d = S_WSTB;
        end
        S_WSTB: begin
          wr_en_d = 1'b1;
          sr_d    = '0;
          state_d = S_DONE;
        end
        S_RDREQ: state_d = S_RDCAP;
        S_RDCAP: begin
          tx_d    = reg_rdata;
          state_d = S_READ;
        end
        S_READ: begin
          // The fall right after the last address bit presents the MSB; shifting starts after the first data rise.
          if (sck_rise) begin
            cnt_d = cnt_q + 1'b1;
            if (data_last) begin
              cnt_d   = '0;
              tx_d    = '0;
              state_d = S_DONE;
            end
          end else if (sck_fall && (cnt_q != '0)) begin
            tx_d = tx_q << 1;
          end
        end
        S_DONE: begin
          if (cs_s) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            sr_d    = '0;
            tx_d    = '0;
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
          sr_d    = '0;
          tx_d    = '0;
        end
      endcase
    end
  end

  always_ff @(posedge sclk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      cmd_q   <= '0;
      tx_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_en_q <= 1'b0;
      rd_en_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      cmd_q   <= cmd_d;
      tx_q    <= tx_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wr_en_q <= wr_en_d;
      rd_en_q <= rd_en_d;
      ferr_q  <= ferr_d;
    end
  end

  assign miso      = (state_q == S_READ) & tx_q[DATA_WIDTH-1];
  assign miso_oe   = (state_q == S_READ);
  assign reg_addr  = addr_q;
  assign reg_wdata = wdata_q;
  assign reg_wr_en = wr_en_q;
  assign reg_rd_en = rd_en_q;
  assign busy      = (state_q != S_IDLE);
  assign frame_err = ferr_q;

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: SPI master model driving frames, scoreboard of expected register-bank strobes.
`timescale 1ns/1ps
module tb_spi_slave;
  localparam int HALF = 80;

  logic       sclk    = 1'b0;
  logic       rst_n   = 1'b0;
  logic       spi_clk = 1'b0;
  logic       cs_n    = 1'b1;
  logic       mosi    = 1'b0;
  logic       miso;
  logic       miso_oe;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_wr_en;
  logic       reg_rd_en;
  logic [7:0] reg_rdata = 8'hA5;
  logic       busy;
  logic       frame_err;

  int n_chk    = 0;
  int n_fail   = 0;
  int ferr_cnt = 0;
  int wr_cnt   = 0;
  int rd_cnt   = 0;

  logic [15:0] exp_wr_q[$];
  logic [7:0]  exp_rd_q[$];
  logic [15:0] wr_e;
  logic [7:0]  rd_e;
  logic [7:0]  rd_val     = 8'h00;
  logic [7:0]  rx;
  logic        oe_allowed = 1'b0;
  logic        oe_seen    = 1'b0;
  logic        prev_oe    = 1'b0;
  time         last_rise_t = 0;

  always #5 sclk = ~sclk;

  spi_slave dut (
    .sclk      (sclk),
    .rst_n     (rst_n),
    .spi_clk   (spi_clk),
    .cs_n      (cs_n),
    .mosi      (mosi),
    .miso      (miso),
    .miso_oe   (miso_oe),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_wr_en (reg_wr_en),
    .reg_rd_en (reg_rd_en),
    .reg_rdata (reg_rdata),
    .busy      (busy),
    .frame_err (frame_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Register bank model: read data is valid exactly one cycle after reg_rd_en.
  always @(posedge sclk) reg_rdata <= reg_rd_en ? rd_val : 8'hA5;

  always @(negedge sclk) begin
    if (rst_n) begin
      if (reg_wr_en) begin
        wr_cnt++;
        check_eq("wr_expected", exp_wr_q.size() > 0, 1);
        if (exp_wr_q.size() > 0) begin
          wr_e = exp_wr_q.pop_front();
          check_eq("wr_addr", reg_addr, wr_e[15:8]);
          check_eq("wr_data", reg_wdata, wr_e[7:0]);
          check_eq("wr_latency", int'(($time - last_rise_t) / 10), 5);
        end
      end
      if (reg_rd_en) begin
        rd_cnt++;
        check_eq("rd_expected", exp_rd_q.size() > 0, 1);
        if (exp_rd_q.size() > 0) begin
          rd_e = exp_rd_q.pop_front();
          check_eq("rd_addr", reg_addr, rd_e);
        end
      end
      if (frame_err) ferr_cnt++;
      if (miso_oe) begin
        oe_seen = 1'b1;
        if (!prev_oe) begin
          check_eq("oe_in_read_frame", oe_allowed, 1);
          check_eq("rd_miso_latency_le6", (($time - last_rise_t) / 10) <= 6, 1);
        end
      end
      prev_oe = miso_oe;
    end
  end

  task automatic spi_bits(input logic [7:0] b, input int n, output logic [7:0] d);
    d = '0;
    for (int i = 7; i > 7 - n; i--) begin
      mosi = b[i];
      #HALF;
      spi_clk     = 1'b1;
      last_rise_t = $time;
      d[i]        = miso;
      #HALF;
      spi_clk = 1'b0;
    end
  endtask

  task automatic spi_byte(input logic [7:0] b);
    logic [7:0] d;
    spi_bits(b, 8, d);
  endtask

  task automatic cs_start();
    cs_n = 1'b0;
    #HALF;
  endtask

  task automatic cs_end(input string tag);
    #HALF;
    cs_n = 1'b1;
    mosi = 1'b0;
    #(4 * HALF);
    check_eq(tag, busy, 0);
  endtask

  task automatic wr_frame(input logic [7:0] a, input logic [7:0] d, input string tag);
    exp_wr_q.push_back({a, d});
    cs_start();
    spi_byte(8'h01);
    spi_byte(a);
    spi_byte(d);
    cs_end(tag);
  endtask

  task automatic rd_frame(input logic [7:0] a, input logic [7:0] v, output logic [7:0] d);
    exp_rd_q.push_back(a);
    rd_val     = v;
    oe_allowed = 1'b1;
    oe_seen    = 1'b0;
    cs_start();
    spi_byte(8'h02);
    spi_byte(a);
    spi_bits(8'h00, 8, d);
    cs_end("rd_busy_low_after");
    oe_allowed = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_miso"}, miso, 0);
    check_eq({tag, "_miso_oe"}, miso_oe, 0);
    check_eq({tag, "_reg_addr"}, reg_addr, 0);
    check_eq({tag, "_reg_wdata"}, reg_wdata, 0);
    check_eq({tag, "_wr_en"}, reg_wr_en, 0);
    check_eq({tag, "_rd_en"}, reg_rd_en, 0);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_frame_err"}, frame_err, 0);
  endtask

  initial begin
    logic [7:0] d;
    #23;
    check_all_zero("in_reset");
    #30;
    rst_n = 1'b1;
    repeat (10) @(negedge sclk);
    check_all_zero("after_reset");

    // Basic write.
    wr_frame(8'h05, 8'hA7, "wr1_busy_low_after");
    check_eq("wr1_ferr", ferr_cnt, 0);
    check_eq("wr1_count", wr_cnt, 1);
    check_eq("wr1_addr_held", reg_addr, 8'h05);

    // Basic read.
    rd_frame(8'h03, 8'h5C, rx);
    check_eq("rd1_miso_data", rx, 8'h5C);
    check_eq("rd1_oe_seen", oe_seen, 1);
    check_eq("rd1_count", rd_cnt, 1);
    check_eq("rd1_oe_low_after", miso_oe, 0);
    check_eq("rd1_ferr", ferr_cnt, 0);

    // Unknown command followed by two more bytes.
    oe_seen = 1'b0;
    cs_start();
    spi_byte(8'h7F);
    check_eq("unk_ferr_after_cmd", ferr_cnt, 1);
    spi_byte(8'h03);
    spi_byte(8'h44);
    cs_end("unk_busy_low_after");
    check_eq("unk_ferr_total", ferr_cnt, 1);
    check_eq("unk_oe_never", oe_seen, 0);
    check_eq("unk_no_wr", wr_cnt, 1);
    check_eq("unk_no_rd", rd_cnt, 1);

    // Write aborted after 4 data bits, then an immediate good write.
    cs_start();
    spi_byte(8'h01);
    spi_byte(8'h22);
    spi_bits(8'hF0, 4, d);
    cs_end("abort_idle_after");
    check_eq("abort_ferr", ferr_cnt, 2);
    check_eq("abort_no_wr", wr_cnt, 1);
    wr_frame(8'h00, 8'hFF, "wr2_busy_low_after");
    check_eq("wr2_count", wr_cnt, 2);
    check_eq("wr2_ferr", ferr_cnt, 2);

    // Reset in the middle of the address field.
    cs_start();
    spi_byte(8'h01);
    spi_bits(8'h10, 4, d);
    check_eq("midaddr_busy", busy, 1);
    #3;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    cs_n    = 1'b1;
    mosi    = 1'b0;
    spi_clk = 1'b0;
    #50;
    rst_n = 1'b1;
    repeat (10) @(negedge sclk);
    wr_frame(8'h10, 8'h33, "wr3_busy_low_after");
    check_eq("wr3_count", wr_cnt, 3);
    check_eq("wr3_ferr", ferr_cnt, 2);

    // Write with trailing bytes ignored in DONE, then a read after a 2-period gap.
    exp_wr_q.push_back({8'h21, 8'h9E});
    cs_start();
    spi_byte(8'h01);
    spi_byte(8'h21);
    spi_byte(8'h9E);
    spi_byte(8'h01);
    spi_byte(8'h55);
    cs_end("b2b_busy_low_between");
    rd_frame(8'h21, 8'hC3, rx);
    check_eq("rd2_miso_data", rx, 8'hC3);
    check_eq("b2b_wr_count", wr_cnt, 4);
    check_eq("b2b_rd_count", rd_cnt, 2);
    check_eq("b2b_ferr", ferr_cnt, 2);

    check_eq("wr_queue_drained", exp_wr_q.size(), 0);
    check_eq("rd_queue_drained", exp_rd_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
- Synthesizable FPGA SPI slave; the target end of the ESP32 SPI master (mode 0: CPOL=0, CPHA=0, MSB first).
- Decodes command/address/data frames arriving on mosi and issues single-cycle write/read strobes to a downstream register bank (brightness registers).
- Returns read data on miso.
- Runs entirely in the sclk domain; SPI inputs are oversampled, with no logic clocked by spi_clk.

Parameters:
- CMD_WIDTH, 8, command field width in bits
- ADDR_WIDTH, 8, address field width in bits
- DATA_WIDTH, 8, data field width in bits (brightness value)
- CMD_WRITE, 8'h01, command code for a register write
- CMD_READ, 8'h02, command code for a register read

Ports:
- sclk  input  1  system clock; must be at least 16x the SPI clock frequency
- rst_n  input  1  asynchronous active-low reset
- spi_clk  input  1  SPI clock from master (master's mclk), asynchronous
- cs_n  input  1  chip select from master, active low, asynchronous
- mosi  input  1  serial data from master, asynchronous
- miso  output  1  serial data to master
- miso_oe  output  1  output enable for the external miso tristate
- reg_addr  output  ADDR_WIDTH  register address, held stable from strobe until next frame
- reg_wdata  output  DATA_WIDTH  write data, valid with reg_wr_en
- reg_wr_en  output  1  one-cycle write strobe
- reg_rd_en  output  1  one-cycle read strobe
- reg_rdata  input  DATA_WIDTH  read data; must be valid the sclk cycle after reg_rd_en
- busy  output  1  high while a frame is in progress (cs_n low, synchronized)
- frame_err  output  1  one-cycle pulse on an aborted frame or unknown command

Behaviour:
- Reset (async assert, sync release internally): all outputs are 0, the FSM is in IDLE, counters are 0, and the synchronizers are preset to spi_clk=0, cs_n=1, mosi=0.
- Synchronization: 2-flop synchronizers on spi_clk, cs_n and mosi, followed by a third register for edge detection.
  - rise = sync & ~prev; fall = ~sync & prev.
  - Effective input latency is 3 sclk cycles.
- Sampling: mosi is shifted in on a detected spi_clk rise; miso is updated on a detected spi_clk fall.
- Bit counter: 3 bits (generic log2 of the field width), cleared on state entry; a field completes on the rise where count == width-1.
- FSM states:
  - IDLE: cs_n falling edge -> COMMAND. miso_oe=0, miso=0.
  - COMMAND: shift CMD_WIDTH bits. On completion:
    - CMD_WRITE or CMD_READ -> ADDRESS.
    - Any other code -> pulse frame_err and go to DONE.
  - ADDRESS: shift ADDR_WIDTH bits into reg_addr.
    - Write command -> WRITE.
    - Read command -> pulse reg_rd_en in the cycle after the last address rise, capture reg_rdata into the tx shift register on the next cycle, then -> READ.
  - WRITE: shift DATA_WIDTH bits. On the last rise, load reg_wdata and pulse reg_wr_en for 1 cycle (2 cycles after the rise), then -> DONE.
  - READ: miso_oe=1.
    - miso = tx MSB from the capture cycle onward; the tx register shifts left on each fall.
    - After DATA_WIDTH rises -> DONE.
  - DONE: miso_oe=0; ignores all further clocks and bytes until cs_n high.
- cs_n deassert (synchronized rise):
  - From any state -> IDLE the next cycle; the bit counter and shift registers are cleared.
  - If the state was COMMAND, ADDRESS, WRITE or READ (frame incomplete), pulse frame_err once, with no reg_wr_en.
  - A completed write has already strobed, so a cs_n rise in DONE is not an error.
- busy = ~cs_n_sync except in IDLE before the first edge.
  - Rises 3 cycles after the cs_n fall; falls on return to IDLE.
- Simultaneous spi_clk edge and cs_n rise in the same cycle: cs_n wins and the edge is discarded.
- Back-to-back frames: a new cs_n fall in the cycle after the return to IDLE is accepted.
- Latency summary:
  - Write: reg_wr_en is asserted 5 sclk cycles after the physical last data spi_clk rise.
  - Read: the first miso bit is valid within 6 sclk cycles after the last address rise. At 16x oversampling this is before the next spi_clk fall (8 cycles).
- Only reset recovers the FSM; no watchdog.

Test Plan:
- Write frame 0x01, 0x05, 0xA7 at sclk = 16x spi_clk -> exactly one reg_wr_en pulse with reg_addr=0x05, reg_wdata=0xA7; frame_err stays 0.
- Read frame 0x02, 0x03 + 8 dummy clocks, with reg_rdata=0x5C one cycle after reg_rd_en -> one reg_rd_en, reg_addr=0x03; master samples 0x5C on miso (MSB first); miso_oe high only during READ.
- Unknown command 0x7F followed by 16 clocks -> frame_err pulses once after the 8th rise; no reg_wr_en or reg_rd_en; miso_oe stays 0.
- Write frame aborted: cs_n released after 4 data bits -> no reg_wr_en; one frame_err pulse; FSM in IDLE; an immediately following valid write (0x01, 0x00, 0xFF) is accepted.
- rst_n asserted mid-ADDRESS -> all outputs 0 asynchronously; after release, a full write frame 0x01, 0x10, 0x33 succeeds.
- Back-to-back write then read, with cs_n high for 2 SPI periods between them, plus 2 extra bytes after a write (DONE) -> exactly one strobe per frame; extra bytes ignored; busy deasserts between frames.
